// File: rtl/frame_serializer_if.sv
// ---------------------------------------------------------------------------
// frame_serializer_if
// Word-level handshake into the frame serializer.
//
// Handshake: a word transfers on the rising clock edge where in_valid and
// in_ready are both high. in_data and in_err_inj are only looked at on that
// edge. in_ready does not depend on in_valid.
//
//   in_data     master -> slave  word to transmit (TXN_SZ bits)
//   in_valid    master -> slave  in_data / in_err_inj are meaningful
//   in_err_inj  master -> slave  send this word with inverted parity
//   in_ready    slave  -> master holding register can take a word
// ---------------------------------------------------------------------------
interface frame_serializer_if #(
    parameter int TXN_SZ = 8
);
    logic [TXN_SZ-1:0] in_data;
    logic              in_valid;
    logic              in_err_inj;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_err_inj,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_err_inj,
        output in_ready
    );
endinterface

// File: rtl/frame_serializer.sv
// ---------------------------------------------------------------------------
// frame_serializer
// Parallel-to-serial transmitter for the single-wire framed link.
// Each word becomes one frame: START(1), TXN_SZ data bits MSB first,
// even-parity bit, STOP(0). The line idles low. A one-entry holding
// register decouples the handshake from the frame in flight.
//
// Ports
//   clock       link bit clock, outputs change on posedge
//   reset       asynchronous, active-high
//   link        word handshake (slave side), see frame_serializer_if
//   sout        serial line
//   busy        a frame (START..STOP) or inter-frame gap is in progress
//   frame_done  one-cycle pulse while STOP is on the line
//   state_dbg   current FSM state encoding
// ---------------------------------------------------------------------------
module frame_serializer #(
    parameter int TXN_SZ   = 8,
    parameter int IDLE_GAP = 0
) (
    input  logic                clock,
    input  logic                reset,
    frame_serializer_if.slave   link,
    output logic                sout,
    output logic                busy,
    output logic                frame_done,
    output logic [2:0]          state_dbg
);

    localparam int CNT_MAX = (TXN_SZ > IDLE_GAP) ? TXN_SZ : IDLE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TXN_SZ-1:0]  shift_q, shift_d;
    logic               parity_q, parity_d;
    logic               hold_valid_q, hold_valid_d;
    logic [TXN_SZ-1:0]  hold_data_q;
    logic               hold_err_q;
    logic               sout_d;
    logic               frame_done_d;
    logic               load;
    logic               accept;

    assign link.in_ready = !hold_valid_q && !reset;
    assign accept        = link.in_valid && link.in_ready;
    assign state_dbg     = state_q;

    // Line outputs are computed for the state being entered, so they change
    // on the same edge as the state register: START goes out on the edge
    // that leaves IDLE, the first data bit on the edge that leaves START.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        sout_d       = 1'b0;
        frame_done_d = 1'b0;
        load         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold_valid_q) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                state_d = S_DATA;
                count_d = CNT_W'(TXN_SZ - 1);
                sout_d  = shift_q[TXN_SZ-1];
                shift_d = shift_q << 1;
            end
            S_DATA: begin
                if (count_q == '0) begin
                    state_d = S_PARITY;
                    sout_d  = parity_q;
                end else begin
                    count_d = count_q - CNT_W'(1);
                    sout_d  = shift_q[TXN_SZ-1];
                    shift_d = shift_q << 1;
                end
            end
            S_PARITY: begin
                state_d      = S_STOP;
                frame_done_d = 1'b1;
            end
            S_STOP: begin
                if (IDLE_GAP > 0) begin
                    state_d = S_GAP;
                    count_d = CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
                end else if (hold_valid_q) begin
                    load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (count_q == '0) begin
                    if (hold_valid_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Moving a word from the holding register into the shifter always
        // starts a new frame.
        if (load) begin
            state_d  = S_START;
            shift_d  = hold_data_q;
            parity_d = (^hold_data_q) ^ hold_err_q;
            sout_d   = 1'b1;
        end
    end

    // A load and an accept cannot both happen on one edge while in_ready is
    // !hold_valid, but if they did the new word would stay held.
    assign hold_valid_d = (hold_valid_q && !load) || accept;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_err_q   <= 1'b0;
            sout         <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            hold_valid_q <= hold_valid_d;
            sout         <= sout_d;
            busy         <= (state_d != S_IDLE);
            frame_done   <= frame_done_d;
            if (accept) begin
                hold_data_q <= link.in_data;
                hold_err_q  <= link.in_err_inj;
            end
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_frame_serializer
// Bench for frame_serializer. dut0 runs with IDLE_GAP=0 and is looped back
// into a receiver model; dut1 runs with IDLE_GAP=3.
// ---------------------------------------------------------------------------
module tb_frame_serializer;

    localparam int TXN_SZ = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frame_serializer_if #(.TXN_SZ(TXN_SZ)) link0 ();
    frame_serializer_if #(.TXN_SZ(TXN_SZ)) link1 ();

    logic       sout0, busy0, done0;
    logic       sout1, busy1, done1;
    logic [2:0] st0, st1;

    frame_serializer #(.TXN_SZ(TXN_SZ), .IDLE_GAP(0)) dut0 (
        .clock      (clk),
        .reset      (reset),
        .link       (link0),
        .sout       (sout0),
        .busy       (busy0),
        .frame_done (done0),
        .state_dbg  (st0)
    );

    frame_serializer #(.TXN_SZ(TXN_SZ), .IDLE_GAP(3)) dut1 (
        .clock      (clk),
        .reset      (reset),
        .link       (link1),
        .sout       (sout1),
        .busy       (busy1),
        .frame_done (done1),
        .state_dbg  (st1)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    int         rx_count = 0;
    logic [7:0] exp_q[$];

    // Expected line sequence of one frame, index 10 is the START bit.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic e);
        return {1'b1, d, (^d) ^ e, 1'b0};
    endfunction

    // Receiver model on dut0's line: samples on negedge, drops frames with
    // bad parity or a missing STOP, checks good frames against exp_q.
    initial begin : rx_model
        int         rx_cnt;
        logic       rx_active;
        logic [7:0] rx_sh;
        logic       rx_par;
        logic [7:0] exp_d;
        rx_cnt    = 0;
        rx_active = 1'b0;
        rx_sh     = '0;
        rx_par    = 1'b0;
        forever begin
            @(negedge clk or posedge reset);
            if (reset) begin
                rx_active = 1'b0;
                rx_cnt    = 0;
            end else if (!rx_active) begin
                if (sout0 === 1'b1) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                if (rx_cnt < 8) begin
                    rx_sh = {rx_sh[6:0], sout0};
                end else if (rx_cnt == 8) begin
                    rx_par = sout0;
                end else begin
                    rx_active = 1'b0;
                    if (sout0 === 1'b0 && ((^rx_sh) ^ rx_par) === 1'b0) begin
                        rx_count++;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL loopback_unexpected: received %h, required no frame", rx_sh);
                        end else begin
                            exp_d = exp_q.pop_front();
                            if (rx_sh !== exp_d) begin
                                n_fail++;
                                $display("FAIL loopback_data: received %h, required %h", rx_sh, exp_d);
                            end
                        end
                    end
                end
                rx_cnt++;
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a negedge. Returns just after the negedge following
    // the accepting posedge, leaving in_valid high.
    task automatic send(input int which, input logic [7:0] d, input logic e);
        int   guard;
        logic rdy;
        if (which == 0) begin
            link0.in_data = d; link0.in_err_inj = e; link0.in_valid = 1'b1;
        end else begin
            link1.in_data = d; link1.in_err_inj = e; link1.in_valid = 1'b1;
        end
        guard = 0;
        rdy   = (which == 0) ? link0.in_ready : link1.in_ready;
        while (rdy !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
            rdy = (which == 0) ? link0.in_ready : link1.in_ready;
        end
        if (guard >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b, required 1 within 100 cycles", rdy);
        end else begin
            @(negedge clk);
            if (which == 0 && !e) exp_q.push_back(d);
        end
    endtask

    // Waits (bounded) until the line shows START at a negedge.
    task automatic wait_start(input int which, output logic found);
        int guard;
        guard = 0;
        found = 1'b0;
        while (guard < 40) begin
            if (((which == 0) ? sout0 : sout1) === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            guard++;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL start_timeout: sout stayed %b, required START within 40 cycles",
                     (which == 0) ? sout0 : sout1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (sout0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: sout/busy/frame_done=%b%b%b, required 000", sout0, busy0, done0);
            end
            n_checks++;
            if (link0.in_ready !== 1'b0 || link1.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready: in_ready=%b/%b, required 0/0", link0.in_ready, link1.in_ready);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (link0.in_ready !== 1'b1 || link1.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: in_ready=%b/%b, required 1/1", link0.in_ready, link1.in_ready);
        end
        n_checks++;
        if (sout0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || st0 !== 3'd0) begin
            n_fail++;
            $display("FAIL release_outputs: sout/busy/done=%b%b%b state=%0d, required 000 state 0",
                     sout0, busy0, done0, st0);
        end
    endtask

    task automatic test_single();
        int          rx0;
        logic [10:0] bits;
        rx0  = rx_count;
        bits = frame_bits(8'hA5, 1'b0);
        send(0, 8'hA5, 1'b0);
        link0.in_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_checks++;
            if (sout0 !== bits[10-i] || done0 !== (i == 10) || busy0 !== 1'b1) begin
                n_fail++;
                $display("FAIL single_bit%0d: sout/done/busy=%b%b%b, required %b%b1",
                         i, sout0, done0, busy0, bits[10-i], (i == 10));
            end
        end
        @(negedge clk);
        n_checks++;
        if (sout0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: sout/busy=%b%b, required 00", sout0, busy0);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (rx_count - rx0 !== 1 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL single_loopback: frames=%0d pending=%0d, required 1 and 0",
                     rx_count - rx0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int          rx0;
        logic [32:0] bits;
        logic        found;
        rx0  = rx_count;
        bits = {frame_bits(8'h01, 1'b0), frame_bits(8'hFF, 1'b0), frame_bits(8'h00, 1'b0)};
        fork
            begin
                send(0, 8'h01, 1'b0);
                send(0, 8'hFF, 1'b0);
                send(0, 8'h00, 1'b0);
                link0.in_valid = 1'b0;
            end
            begin
                wait_start(0, found);
                if (found) begin
                    for (int i = 0; i < 33; i++) begin
                        n_checks++;
                        if (sout0 !== bits[32-i] || done0 !== (i % 11 == 10)) begin
                            n_fail++;
                            $display("FAIL b2b_bit%0d: sout/done=%b%b, required %b%b",
                                     i, sout0, done0, bits[32-i], (i % 11 == 10));
                        end
                        if ((i >= 1 && i <= 10) || (i >= 12 && i <= 21)) begin
                            n_checks++;
                            if (link0.in_ready !== 1'b0) begin
                                n_fail++;
                                $display("FAIL b2b_ready%0d: in_ready=%b, required 0", i, link0.in_ready);
                            end
                        end
                        @(negedge clk);
                    end
                end
            end
        join
        repeat (2) @(negedge clk);
        n_checks++;
        if (rx_count - rx0 !== 3 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_loopback: frames=%0d pending=%0d, required 3 and 0",
                     rx_count - rx0, exp_q.size());
        end
    endtask

    task automatic test_parity_err();
        int          rx0;
        logic [21:0] bits;
        logic        found;
        rx0  = rx_count;
        bits = {frame_bits(8'h01, 1'b1), frame_bits(8'h3C, 1'b0)};
        fork
            begin
                send(0, 8'h01, 1'b1);
                send(0, 8'h3C, 1'b0);
                link0.in_valid   = 1'b0;
                link0.in_err_inj = 1'b0;
            end
            begin
                wait_start(0, found);
                if (found) begin
                    for (int i = 0; i < 22; i++) begin
                        n_checks++;
                        if (sout0 !== bits[21-i]) begin
                            n_fail++;
                            $display("FAIL err_bit%0d: sout=%b, required %b", i, sout0, bits[21-i]);
                        end
                        @(negedge clk);
                    end
                end
            end
        join
        repeat (2) @(negedge clk);
        n_checks++;
        if (rx_count - rx0 !== 1 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL err_loopback: frames=%0d pending=%0d, required 1 and 0",
                     rx_count - rx0, exp_q.size());
        end
    endtask

    task automatic test_idle_gap();
        logic [24:0] bits;
        logic        found;
        bits = {frame_bits(8'h96, 1'b0), 3'b000, frame_bits(8'h3C, 1'b0)};
        fork
            begin
                send(1, 8'h96, 1'b0);
                send(1, 8'h3C, 1'b0);
                link1.in_valid = 1'b0;
            end
            begin
                wait_start(1, found);
                if (found) begin
                    for (int i = 0; i < 25; i++) begin
                        n_checks++;
                        if (sout1 !== bits[24-i] || busy1 !== 1'b1 || done1 !== (i == 10 || i == 24)) begin
                            n_fail++;
                            $display("FAIL gap_bit%0d: sout/busy/done=%b%b%b, required %b1%b",
                                     i, sout1, busy1, done1, bits[24-i], (i == 10 || i == 24));
                        end
                        @(negedge clk);
                    end
                end
            end
        join
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b0 || sout1 !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_idle: busy/sout=%b%b, required 00", busy1, sout1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int          rx0;
        logic [10:0] bits;
        send(0, 8'hC3, 1'b0);
        send(0, 8'h81, 1'b0);
        link0.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b1 || sout0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_frame_bit4: busy/sout=%b%b, required 10", busy0, sout0);
        end
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        n_checks++;
        if (sout0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || link0.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: sout/busy/done/ready=%b%b%b%b, required 0000",
                     sout0, busy0, done0, link0.in_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (busy0 !== 1'b0 || sout0 !== 1'b0) begin
                n_fail++;
                $display("FAIL held_word_lost: busy/sout=%b%b, required 00", busy0, sout0);
            end
        end
        rx0  = rx_count;
        bits = frame_bits(8'h5A, 1'b0);
        send(0, 8'h5A, 1'b0);
        link0.in_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_checks++;
            if (sout0 !== bits[10-i]) begin
                n_fail++;
                $display("FAIL after_reset_bit%0d: sout=%b, required %b", i, sout0, bits[10-i]);
            end
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (rx_count - rx0 !== 1 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL after_reset_loopback: frames=%0d pending=%0d, required 1 and 0",
                     rx_count - rx0, exp_q.size());
        end
    endtask

    task automatic test_random();
        int         rx0;
        int         n_good;
        int         guard;
        logic [7:0] d;
        logic       e;
        rx0    = rx_count;
        n_good = 0;
        for (int k = 0; k < 1000; k++) begin
            int idle;
            idle = $urandom_range(0, 2);
            if (idle > 0) begin
                link0.in_valid = 1'b0;
                repeat (idle) @(negedge clk);
            end
            d = 8'($urandom_range(0, 255));
            e = ($urandom_range(0, 15) == 0);
            if (!e) n_good++;
            send(0, d, e);
        end
        link0.in_valid   = 1'b0;
        link0.in_err_inj = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (15) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0 || rx_count - rx0 !== n_good) begin
            n_fail++;
            $display("FAIL random_stream: received=%0d pending=%0d, required %0d and 0",
                     rx_count - rx0, exp_q.size(), n_good);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        link0.in_data = '0; link0.in_valid = 1'b0; link0.in_err_inj = 1'b0;
        link1.in_data = '0; link1.in_valid = 1'b0; link1.in_err_inj = 1'b0;
        test_reset();
        test_single();
        repeat (3) @(negedge clk);
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_parity_err();
        repeat (3) @(negedge clk);
        test_idle_gap();
        repeat (3) @(negedge clk);
        test_reset_mid_frame();
        repeat (3) @(negedge clk);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
